// File: rtl/bs_pkg.sv
// Shared definitions for the bit-serial modular multiplier collector.
//   MODULUS        : modulus used by the upstream bit-serial multiplier
//   OP_LEN/PROD_LEN: default operand and product word lengths in bits
//   state_t        : collector FSM states
//   clog2()        : ceiling log2, usable in constant expressions
package bs_pkg;

  localparam int MODULUS  = 29;
  localparam int OP_LEN   = 24;
  localparam int PROD_LEN = 48;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/bs_sync_fifo.sv
// Synchronous FIFO with registered head output.
//   clk, reset : clock, asynchronous active-low reset (clears pointers)
//   i_push     : write i_data; accepted when not full, or when full and popping
//   i_pop      : remove head entry; ignored while empty
//   o_data     : head entry, forced to zero while empty
//   o_level    : occupancy 0..DEPTH
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
module bs_sync_fifo
  import bs_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic [clog2(DEPTH):0]  o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;

  // When full, a simultaneous pop frees the head slot, which the push reuses.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || i_pop);

  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/bs_collect.sv
// Collects LSB-first serial words framed by a one-cycle isync pulse into
// LEN-bit parallel words and queues them for a valid/ready consumer.
//   clk, reset : clock, asynchronous active-low reset
//   i, isync   : serial bit and frame-start marker (high with bit 0)
//   o_data     : head-of-queue word, valid while o_valid
//   o_valid    : queue non-empty
//   o_ready    : consumer accepts o_data on a rising edge with o_valid
//   osync      : one-cycle pulse after each completed word (pushed or dropped)
//   level      : queue occupancy 0..DEPTH
//   overrun    : sticky, a completed word was dropped on a full queue
module bs_collect
  import bs_pkg::*;
#(
  parameter int LEN   = PROD_LEN,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i,
  input  logic                   isync,
  output logic [LEN-1:0]         o_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   osync,
  output logic [clog2(DEPTH):0]  level,
  output logic                   overrun
);

  localparam int CNT_W = clog2(LEN);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [LEN-1:0]   r_shreg;
  logic [LEN-1:0]   w_shreg_nxt;
  logic [LEN-1:0]   w_word;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic             r_osync;
  logic             r_overrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  // isync takes priority in both states: it always starts a fresh word,
  // abandoning any partial one without a push.
  always_comb begin
    w_state_nxt         = r_state;
    w_cnt_nxt           = r_cnt;
    w_shreg_nxt         = r_shreg;
    w_push              = 1'b0;
    w_word              = r_shreg;
    w_word[LEN-1]       = i;
    if (isync) begin
      w_state_nxt    = SHIFT;
      w_cnt_nxt      = CNT_W'(1);
      w_shreg_nxt    = '0;
      w_shreg_nxt[0] = i;
    end else if (r_state == SHIFT) begin
      w_shreg_nxt[r_cnt] = i;
      if (r_cnt == CNT_W'(LEN - 1)) begin
        // Final bit goes straight into the pushed word via w_word.
        w_push      = 1'b1;
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  // A full queue only drops the word if the consumer is not popping this edge.
  assign w_drop = w_push && w_full && !o_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_osync   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_osync <= w_push;
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  bs_sync_fifo #(
    .WIDTH (LEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (o_ready),
    .i_data  (w_word),
    .o_data  (o_data),
    .o_level (level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_valid = !w_empty;
  assign osync   = r_osync;
  assign overrun = r_overrun;

endmodule
